// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end with one-word holding register
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   data_in     WIDTH-bit word to serialize
//   data_valid  data_in carries a word
//   data_ready  a word can be accepted this cycle
//   out_bit     serial stream (IDLE_BIT between words)
//   out_valid   out_bit carries a data bit
//   frame_start out_bit is the first bit of a word
//   busy        shifter active or holding register occupied
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [CW-1:0]    bit_cnt;

    logic             transfer;
    logic             head_bit;
    logic [WIDTH-1:0] shifted;

    assign transfer = data_valid && data_ready;

    // The head of shift_reg is always the bit on the line; shifting moves the
    // next bit of the word into the head position.
    generate
        if (MSB_FIRST) begin : g_msb
            assign head_bit = shift_reg[WIDTH-1];
            assign shifted  = {shift_reg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign head_bit = shift_reg[0];
            assign shifted  = {1'b0, shift_reg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        shift_reg <= data_in;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt != LAST_CNT) begin
                        shift_reg <= shifted;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (transfer) begin
                            hold_reg  <= data_in;
                            hold_full <= 1'b1;
                        end
                    end else if (hold_full) begin
                        // Held word takes the shifter first; a simultaneous
                        // transfer refills the slot it just vacated.
                        shift_reg <= hold_reg;
                        bit_cnt   <= '0;
                        if (transfer) begin
                            hold_reg  <= data_in;
                            hold_full <= 1'b1;
                        end else begin
                            hold_full <= 1'b0;
                        end
                    end else if (transfer) begin
                        // Word arriving on the last-bit edge follows with no gap.
                        shift_reg <= data_in;
                        bit_cnt   <= '0;
                    end else begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bit_cnt   <= '0;
                    hold_full <= 1'b0;
                end
            endcase
        end
    end

    // data_ready is forced low while reset is asserted so nothing is taken
    // on the release edge.
    assign data_ready  = !hold_full && !reset;
    assign out_bit     = (state == SHIFT) ? head_bit : IDLE_BIT;
    assign out_valid   = (state == SHIFT);
    assign frame_start = (state == SHIFT) && (bit_cnt == '0);
    assign busy        = (state == SHIFT) || hold_full;

endmodule
